// File: rtl/modulo_folding_encoder_if.sv
// Sample-in / code-out bus of the modulo folding encoder.
// The master drives samples and the slave (the encoder) returns folded ADC codes.
interface modulo_folding_encoder_if #(
  parameter int WIDTH = 24
);
  logic             valid_in;
  logic [WIDTH-1:0] x_in;
  logic             in_ready;
  logic             valid_out;
  logic [11:0]      adc_code;
  logic [4:0]       fold_count;
  logic             overrange;

  modport master (
    output valid_in, x_in,
    input  in_ready, valid_out, adc_code, fold_count, overrange
  );

  modport slave (
    input  valid_in, x_in,
    output in_ready, valid_out, adc_code, fold_count, overrange
  );
endinterface

// File: rtl/modulo_folding_encoder.sv
// Folds an unfolded signed sample into [-LAMBDA, LAMBDA) one step per cycle.
// Emits the self-reset ADC code, the signed fold count and an overrange flag.
module modulo_folding_encoder #(
  parameter int              WIDTH           = 24,
  parameter int              FRACTIONAL_BITS = 16,
  parameter logic [WIDTH-1:0] LAMBDA         = 24'h00C000,
  parameter int unsigned     ADC_GAIN        = 2731,
  parameter int              MAX_FOLDS       = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  modulo_folding_encoder_if.slave   bus
);

  localparam int AW = WIDTH + 2;   // accumulator width, wide enough that folding never wraps
  localparam int PW = AW + 12;     // scaled product width
  localparam int CW = PW - FRACTIONAL_BITS;

  localparam logic signed [AW-1:0] LAM   = AW'(LAMBDA);
  localparam logic signed [AW-1:0] LAM_N = -LAM;
  localparam logic signed [AW-1:0] LAM2  = LAM + LAM;
  localparam logic signed [4:0]    KMAX  = 5'(MAX_FOLDS);
  localparam logic signed [4:0]    KMIN  = -KMAX;

  typedef enum logic [1:0] {IDLE, FOLD, SCALE, OUT} state_t;

  typedef struct packed {
    logic        valid;
    logic [11:0] code;
    logic [4:0]  folds;
    logic        ovr;
  } result_t;

  state_t               state, state_nxt;
  logic signed [AW-1:0] acc;
  logic signed [4:0]    k;
  logic                 ovr;
  logic [11:0]          code_q;
  result_t              res;

  logic above, below, at_max;
  logic fold_up, fold_dn, set_ovr;

  logic signed [AW:0]   shifted;
  logic [PW-1:0]        prod;
  logic [CW-1:0]        code_full;
  logic [11:0]          code_c;

  assign above  = (acc >= LAM);
  assign below  = (acc < LAM_N);
  assign at_max = (k == KMAX) || (k == KMIN);

  always_comb begin
    state_nxt = state;
    fold_up   = 1'b0;
    fold_dn   = 1'b0;
    set_ovr   = 1'b0;
    case (state)
      IDLE:  if (bus.valid_in) state_nxt = FOLD;
      FOLD: begin
        if (above || below) begin
          // Out of range with the fold budget spent: give up and clamp.
          if (at_max) begin
            set_ovr   = 1'b1;
            state_nxt = SCALE;
          end else begin
            fold_up = above;
            fold_dn = below;
          end
        end else begin
          state_nxt = SCALE;
        end
      end
      SCALE: state_nxt = OUT;
      OUT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift the folded value to [0, 2*LAMBDA) and scale to 12 bits.
  always_comb begin
    shifted   = {acc[AW-1], acc} + {1'b0, LAM};
    prod      = PW'(shifted[AW-1:0]) * PW'(ADC_GAIN);
    code_full = prod[PW-1:FRACTIONAL_BITS];
    code_c    = code_full[11:0];
    if (shifted[AW])
      code_c = 12'd0;
    else if ((ovr && above) || (code_full > CW'(4095)))
      code_c = 12'd4095;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      k      <= '0;
      ovr    <= 1'b0;
      code_q <= '0;
      res    <= '0;
    end else if (clk_en) begin
      state     <= state_nxt;
      res.valid <= (state == OUT);
      case (state)
        IDLE: if (bus.valid_in) begin
          acc <= {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
          k   <= '0;
          ovr <= 1'b0;
        end
        FOLD: begin
          if (fold_up) begin
            acc <= acc - LAM2;
            k   <= k + 5'sd1;
          end else if (fold_dn) begin
            acc <= acc + LAM2;
            k   <= k - 5'sd1;
          end
          if (set_ovr) ovr <= 1'b1;
        end
        SCALE: code_q <= code_c;
        OUT: begin
          res.code  <= code_q;
          res.folds <= k;
          res.ovr   <= ovr;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.valid_out  = res.valid;
  assign bus.adc_code   = res.code;
  assign bus.fold_count = res.folds;
  assign bus.overrange  = res.ovr;

endmodule
